alu_seq_ctrl: RTL and testbench

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_seq_pkg.sv | 62 ++++++
 rtl/alu_seq_decode.sv | 64 ++++++
 rtl/alu_seq_ctrl.sv | 178 +++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the multi-cycle ALU sequencer: FSM states, ALU operation codes,
// RV32 opcode values, instruction class codes and ALU operand-select encodings.
package alu_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5
   } state_t;

   localparam logic [3:0] ALU_NONE = 4'b0000;
   localparam logic [3:0] ALU_ADD  = 4'b0001;
   localparam logic [3:0] ALU_SUB  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0111;
   localparam logic [3:0] ALU_OR   = 4'b1000;
   localparam logic [3:0] ALU_BEQ  = 4'b1001;
   localparam logic [3:0] ALU_BNE  = 4'b1100;
   localparam logic [3:0] ALU_BLT  = 4'b1101;
   localparam logic [3:0] ALU_BGE  = 4'b1110;
   localparam logic [3:0] ALU_JALR = 4'b1111;

   localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [2:0] CLS_RTYPE   = 3'd0;
   localparam logic [2:0] CLS_ITYPE   = 3'd1;
   localparam logic [2:0] CLS_LOAD    = 3'd2;
   localparam logic [2:0] CLS_STORE   = 3'd3;
   localparam logic [2:0] CLS_BRANCH  = 3'd4;
   localparam logic [2:0] CLS_JAL     = 3'd5;
   localparam logic [2:0] CLS_JALR    = 3'd6;
   localparam logic [2:0] CLS_ILLEGAL = 3'd7;

   localparam logic       SRC_A_RS1  = 1'b0;
   localparam logic       SRC_A_PC   = 1'b1;
   localparam logic [1:0] SRC_B_RS2  = 2'd0;
   localparam logic [1:0] SRC_B_IMM  = 2'd1;
   localparam logic [1:0] SRC_B_FOUR = 2'd2;

   function automatic logic is_mem_class(input logic [2:0] cls);
      return (cls == CLS_LOAD) || (cls == CLS_STORE);
   endfunction

   function automatic logic is_jump(input logic [2:0] cls);
      return (cls == CLS_JAL) || (cls == CLS_JALR);
   endfunction

   // Branch and jal targets are PC-relative; everything else computes from rs1.
   function automatic logic uses_pc_base(input logic [2:0] cls);
      return (cls == CLS_BRANCH) || (cls == CLS_JAL);
   endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational instruction decoder: maps an RV32 instruction word to an instruction
// class and ALU operation code; unsupported opcode/funct3 combinations are flagged illegal.
module alu_seq_decode
   import alu_seq_pkg::*;
(
   input  logic [31:0] instr,
   output logic [2:0]  op_class,
   output logic [3:0]  alu_ctl,
   output logic        illegal
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       alt;
   logic       unused_bits;

   assign opcode      = instr[6:0];
   assign funct3      = instr[14:12];
   assign alt         = instr[30];
   assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

   always_comb begin
      op_class = CLS_ILLEGAL;
      alu_ctl  = ALU_NONE;
      case (opcode)
         OPC_RTYPE: begin
            case (funct3)
               3'b000: begin op_class = CLS_RTYPE; alu_ctl = alt ? ALU_SUB : ALU_ADD; end
               3'b010: begin op_class = CLS_RTYPE; alu_ctl = ALU_SLT; end
               3'b110: begin op_class = CLS_RTYPE; alu_ctl = ALU_OR;  end
               3'b111: begin op_class = CLS_RTYPE; alu_ctl = ALU_AND; end
               default: ;
            endcase
         end
         // Bit 30 is immediate data here, so addi never becomes a subtract.
         OPC_ITYPE: begin
            case (funct3)
               3'b000: begin op_class = CLS_ITYPE; alu_ctl = ALU_ADD; end
               3'b010: begin op_class = CLS_ITYPE; alu_ctl = ALU_SLT; end
               3'b110: begin op_class = CLS_ITYPE; alu_ctl = ALU_OR;  end
               3'b111: begin op_class = CLS_ITYPE; alu_ctl = ALU_AND; end
               default: ;
            endcase
         end
         OPC_LOAD:  begin op_class = CLS_LOAD;  alu_ctl = ALU_ADD; end
         OPC_STORE: begin op_class = CLS_STORE; alu_ctl = ALU_ADD; end
         OPC_BRANCH: begin
            case (funct3)
               3'b000: begin op_class = CLS_BRANCH; alu_ctl = ALU_BEQ; end
               3'b001: begin op_class = CLS_BRANCH; alu_ctl = ALU_BNE; end
               3'b100: begin op_class = CLS_BRANCH; alu_ctl = ALU_BLT; end
               3'b101: begin op_class = CLS_BRANCH; alu_ctl = ALU_BGE; end
               default: ;
            endcase
         end
         OPC_JAL:  begin op_class = CLS_JAL;  alu_ctl = ALU_ADD;  end
         OPC_JALR: begin op_class = CLS_JALR; alu_ctl = ALU_JALR; end
         default: ;
      endcase
   end

   assign illegal = (op_class == CLS_ILLEGAL);

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle instruction sequencer (IDLE/FETCH/DECODE/EXEC/MEM/WB) driving ALU and datapath strobes.
// Define ALU_SEQ_CTRL_PERF_EN to add the cycle_cnt / retire_cnt performance counters.
module alu_seq_ctrl
   import alu_seq_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] instr,
   input  logic        mem_ready,
   input  logic        stop,
   output logic [3:0]  alu_ctl,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic        ir_write,
   output logic        mem_read,
   output logic        mem_write,
   output logic        reg_write,
   output logic        pc_write,
   output logic        busy,
   output logic        done,
   output logic        err
`ifdef ALU_SEQ_CTRL_PERF_EN
   ,
   output logic [31:0] cycle_cnt,
   output logic [31:0] retire_cnt
`endif
);

   state_t      state_q;
   state_t      state_d;
   state_t      finish_state;
   logic [31:0] ir_q;
   logic [2:0]  cls_q;
   logic [3:0]  alu_q;
   logic        stop_pend;

   logic [2:0]  dec_class;
   logic [3:0]  dec_alu;
   logic        dec_illegal;

   // Decoding works from the captured instruction word so instr may change after fetch.
   alu_seq_decode u_decode (
      .instr    (ir_q),
      .op_class (dec_class),
      .alu_ctl  (dec_alu),
      .illegal  (dec_illegal)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir_q  <= '0;
         cls_q <= CLS_ILLEGAL;
         alu_q <= ALU_NONE;
      end else begin
         if (state_q == ST_FETCH && mem_ready) begin
            ir_q <= instr;
         end
         if (state_q == ST_DECODE) begin
            cls_q <= dec_class;
            alu_q <= dec_alu;
         end
      end
   end

   // A stop seen at any point of an instruction is remembered until it retires.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stop_pend <= 1'b0;
      end else if (state_q == ST_IDLE) begin
         stop_pend <= 1'b0;
      end else if (stop) begin
         stop_pend <= 1'b1;
      end
   end

   assign finish_state = (stop || stop_pend) ? ST_IDLE : ST_FETCH;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start) state_d = ST_FETCH;
         ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
         ST_DECODE: state_d = dec_illegal ? ST_IDLE : ST_EXEC;
         ST_EXEC: begin
            if (cls_q == CLS_BRANCH) begin
               state_d = finish_state;
            end else if (is_mem_class(cls_q)) begin
               state_d = ST_MEM;
            end else begin
               state_d = ST_WB;
            end
         end
         ST_MEM: begin
            if (mem_ready) begin
               state_d = (cls_q == CLS_LOAD) ? ST_WB : finish_state;
            end
         end
         ST_WB:   state_d = finish_state;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      alu_ctl   = ALU_NONE;
      alu_src_a = SRC_A_RS1;
      alu_src_b = SRC_B_RS2;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      pc_write  = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      case (state_q)
         ST_FETCH: begin
            mem_read = 1'b1;
            ir_write = mem_ready;
         end
         ST_DECODE: err = dec_illegal;
         ST_EXEC: begin
            alu_ctl   = alu_q;
            alu_src_a = uses_pc_base(cls_q) ? SRC_A_PC : SRC_A_RS1;
            alu_src_b = (cls_q == CLS_RTYPE) ? SRC_B_RS2 : SRC_B_IMM;
            if (cls_q == CLS_BRANCH) begin
               pc_write = 1'b1;
               done     = 1'b1;
            end
         end
         ST_MEM: begin
            alu_ctl   = alu_q;
            alu_src_b = SRC_B_IMM;
            mem_read  = (cls_q == CLS_LOAD);
            mem_write = (cls_q == CLS_STORE);
            done      = (cls_q == CLS_STORE) && mem_ready;
         end
         // Jumps load the ALU target into PC; everything else advances by 4.
         ST_WB: begin
            reg_write = 1'b1;
            pc_write  = 1'b1;
            done      = 1'b1;
            if (is_jump(cls_q)) begin
               alu_ctl   = alu_q;
               alu_src_a = uses_pc_base(cls_q) ? SRC_A_PC : SRC_A_RS1;
               alu_src_b = SRC_B_IMM;
            end else begin
               alu_ctl   = ALU_ADD;
               alu_src_a = SRC_A_PC;
               alu_src_b = SRC_B_FOUR;
            end
         end
         default: ;
      endcase
   end

   assign busy = (state_q != ST_IDLE);

`ifdef ALU_SEQ_CTRL_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt  <= '0;
         retire_cnt <= '0;
      end else begin
         if (busy) cycle_cnt  <= cycle_cnt + 32'd1;
         if (done) retire_cnt <= retire_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: per-cycle output vector checks plus a latency scoreboard
// (expected instruction latency queued at issue, popped when the DUT pulses done).
module tb_alu_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] instr = 32'd0;
   logic        mem_ready = 1'b0;
   logic        stop = 1'b0;
   logic [3:0]  alu_ctl;
   logic        alu_src_a;
   logic [1:0]  alu_src_b;
   logic        ir_write, mem_read, mem_write, reg_write, pc_write;
   logic        busy, done, err;
`ifdef ALU_SEQ_CTRL_PERF_EN
   logic [31:0] cycle_cnt, retire_cnt;
`endif

   alu_seq_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .instr     (instr),
      .mem_ready (mem_ready),
      .stop      (stop),
      .alu_ctl   (alu_ctl),
      .alu_src_a (alu_src_a),
      .alu_src_b (alu_src_b),
      .ir_write  (ir_write),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .reg_write (reg_write),
      .pc_write  (pc_write),
      .busy      (busy),
      .done      (done),
      .err       (err)
`ifdef ALU_SEQ_CTRL_PERF_EN
      ,
      .cycle_cnt (cycle_cnt),
      .retire_cnt(retire_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Vector layout: {alu_ctl, src_a, src_b, ir_write, mem_read, mem_write, reg_write, pc_write, busy, done, err}
   logic [14:0] outs;
   assign outs = {alu_ctl, alu_src_a, alu_src_b, ir_write, mem_read, mem_write,
                  reg_write, pc_write, busy, done, err};

   localparam logic [14:0] V_IDLE   = 15'd0;
   localparam logic [14:0] V_FETCH  = {4'h0, 1'b0, 2'd0, 5'b11000, 3'b100};
   localparam logic [14:0] V_DECODE = {4'h0, 1'b0, 2'd0, 5'b00000, 3'b100};
   localparam logic [14:0] V_WB     = {4'h1, 1'b1, 2'd2, 5'b00011, 3'b110};

   int total = 0;
   int bad = 0;
   int lat = 0;
   int sb[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_instr(input int cycles);
      sb.push_back(cycles);
      lat = 0;
   endtask

   // Inputs are already driven; sample mid-cycle, score any retire, then advance one clock.
   task automatic cyc_chk(input string tag, input logic [14:0] exp);
      int exp_lat;
      #1;
      check(tag, 32'(outs), 32'(exp));
      if (busy) lat++;
      if (done) begin
         check({tag, "_sb_pending"}, 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            exp_lat = sb.pop_front();
            check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
         end
      end
      @(posedge clk);
      #2;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #2;
      check("reset_outs", 32'(outs), 32'd0);
`ifdef ALU_SEQ_CTRL_PERF_EN
      check("reset_cycle_cnt", cycle_cnt, 32'd0);
      check("reset_retire_cnt", retire_cnt, 32'd0);
`endif
      rst_n = 1'b1;

      // add x3,x1,x2 then bne, lw with three wait states, sw with stop
      start = 1'b1;
      push_instr(4);
      cyc_chk("add_idle", V_IDLE);
      start = 1'b0; instr = 32'h002081B3; mem_ready = 1'b1;
      cyc_chk("add_fetch", V_FETCH);
      cyc_chk("add_decode", V_DECODE);
      cyc_chk("add_exec", {4'h1, 1'b0, 2'd0, 5'b00000, 3'b100});
      cyc_chk("add_wb", V_WB);

      push_instr(3); instr = 32'h00209463;
      cyc_chk("bne_fetch", V_FETCH);
      cyc_chk("bne_decode", V_DECODE);
      cyc_chk("bne_exec", {4'hC, 1'b1, 2'd1, 5'b00001, 3'b110});

      push_instr(8); instr = 32'h0000A283;
      cyc_chk("lw_fetch", V_FETCH);
      mem_ready = 1'b0;
      cyc_chk("lw_decode", V_DECODE);
      cyc_chk("lw_exec", {4'h1, 1'b0, 2'd1, 5'b00000, 3'b100});
      for (int i = 0; i < 3; i++) cyc_chk("lw_mem_wait", {4'h1, 1'b0, 2'd1, 5'b01000, 3'b100});
      mem_ready = 1'b1;
      cyc_chk("lw_mem_ready", {4'h1, 1'b0, 2'd1, 5'b01000, 3'b100});
      cyc_chk("lw_wb", V_WB);

      push_instr(4); instr = 32'h0020A223;
      cyc_chk("sw_fetch", V_FETCH);
      cyc_chk("sw_decode", V_DECODE);
      cyc_chk("sw_exec", {4'h1, 1'b0, 2'd1, 5'b00000, 3'b100});
      stop = 1'b1;
      cyc_chk("sw_mem", {4'h1, 1'b0, 2'd1, 5'b00100, 3'b110});
      stop = 1'b0;
      cyc_chk("sw_idle_after", V_IDLE);

      // illegal opcode 7'b1111111
      start = 1'b1; instr = 32'hFFFFFFFF;
      cyc_chk("ill_idle", V_IDLE);
      start = 1'b0;
      cyc_chk("ill_fetch", V_FETCH);
      cyc_chk("ill_decode", {4'h0, 1'b0, 2'd0, 5'b00000, 3'b101});
      cyc_chk("ill_after", V_IDLE);

      // asynchronous reset while a load waits in MEM
      start = 1'b1; instr = 32'h0000A283;
      cyc_chk("rst_idle", V_IDLE);
      start = 1'b0;
      cyc_chk("rst_fetch", V_FETCH);
      mem_ready = 1'b0;
      cyc_chk("rst_decode", V_DECODE);
      cyc_chk("rst_exec", {4'h1, 1'b0, 2'd1, 5'b00000, 3'b100});
      #1;
      check("rst_mem", 32'(outs), 32'({4'h1, 1'b0, 2'd1, 5'b01000, 3'b100}));
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_async", 32'(outs), 32'd0);
      start = 1'b1; mem_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #2;
         check("rst_held", 32'(outs), 32'd0);
      end
`ifdef ALU_SEQ_CTRL_PERF_EN
      check("rst_cycle_cnt", cycle_cnt, 32'd0);
`endif
      rst_n = 1'b1; start = 1'b0;
      cyc_chk("rst_release_idle", V_IDLE);

      // sub with stop pulsed during EXEC
      start = 1'b1; instr = 32'h402081B3;
      push_instr(4);
      cyc_chk("sub_idle", V_IDLE);
      start = 1'b0;
      cyc_chk("sub_fetch", V_FETCH);
      cyc_chk("sub_decode", V_DECODE);
      stop = 1'b1;
      cyc_chk("sub_exec", {4'h4, 1'b0, 2'd0, 5'b00000, 3'b100});
      stop = 1'b0;
      cyc_chk("sub_wb", V_WB);
      cyc_chk("sub_idle_after", V_IDLE);
`ifdef ALU_SEQ_CTRL_PERF_EN
      check("sub_retire_cnt", retire_cnt, 32'd1);
      check("sub_cycle_cnt", cycle_cnt, 32'd4);
`endif

      // jal x1,8 with stop during WB
      start = 1'b1; instr = 32'h008000EF;
      push_instr(4);
      cyc_chk("jal_idle", V_IDLE);
      start = 1'b0;
      cyc_chk("jal_fetch", V_FETCH);
      cyc_chk("jal_decode", V_DECODE);
      cyc_chk("jal_exec", {4'h1, 1'b1, 2'd1, 5'b00000, 3'b100});
      stop = 1'b1;
      cyc_chk("jal_wb", {4'h1, 1'b1, 2'd1, 5'b00011, 3'b110});
      stop = 1'b0;
      cyc_chk("jal_idle_after", V_IDLE);

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
